// File: rtl/k_fifo_pkg.sv
// Shared constants and pointer helpers for the k_fifo family.
// Pointers carry one extra wrap bit above the RAM address bits.
package k_fifo_pkg;

    localparam int DATA_SIZE_DEF = 8;
    localparam int ADDR_SIZE_DEF = 1;
    localparam int PTR_W_MAX     = 16;

    // Increment modulo 2**ptr_w; the caller truncates to its own pointer width.
    function automatic logic [PTR_W_MAX-1:0] ptr_inc(
        input logic [PTR_W_MAX-1:0] ptr,
        input int unsigned          ptr_w = ADDR_SIZE_DEF + 1
    );
        logic [PTR_W_MAX-1:0] mask;
        mask = (PTR_W_MAX'(1) << ptr_w) - PTR_W_MAX'(1);
        return (ptr + PTR_W_MAX'(1)) & mask;
    endfunction

endpackage

// File: rtl/k_dp_ram.sv
// Dual-port register RAM: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module k_dp_ram
    import k_fifo_pkg::*;
#(
    parameter int data_size = DATA_SIZE_DEF,
    parameter int addr_size = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 wen,
    input  logic [addr_size-1:0] waddr,
    input  logic [data_size-1:0] wdata,
    input  logic [addr_size-1:0] raddr,
    output logic [data_size-1:0] rdata
);

    localparam int DEPTH = 1 << addr_size;

    logic [data_size-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/k_fifo_2deep_ctrl.sv
// First-word-fall-through FIFO controller around k_dp_ram.
// Holds only the wrap-bit pointers; occupancy and flags are derived from them.
module k_fifo_2deep_ctrl
    import k_fifo_pkg::*;
#(
    parameter int data_size = DATA_SIZE_DEF,
    parameter int addr_size = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_size-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [data_size-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [addr_size:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam int PW = addr_size + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rptr_nxt;
    logic          push;
    logic          pop;

    assign wptr_nxt = PW'(ptr_inc(PTR_W_MAX'(wptr), PW));
    assign rptr_nxt = PW'(ptr_inc(PTR_W_MAX'(rptr), PW));

    // Full: same RAM slot, opposite lap.
    assign full      = (wptr == {~rptr[addr_size], rptr[addr_size-1:0]});
    assign empty     = (wptr == rptr);
    assign count     = wptr - rptr;

    // in_ready drops during reset so nothing reaches the RAM while rst is high.
    assign in_ready  = ~full & ~rst;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr_nxt;
            end
            if (pop) begin
                rptr <= rptr_nxt;
            end
        end
    end

    k_dp_ram #(
        .data_size (data_size),
        .addr_size (addr_size)
    ) u_ram (
        .clk   (clk),
        .wen   (push),
        .waddr (wptr[addr_size-1:0]),
        .wdata (in_data),
        .raddr (rptr[addr_size-1:0]),
        .rdata (out_data)
    );

endmodule
